// File: rtl/branch_predictor.sv
// Direct-mapped branch history / target table for the fetch stage.
// Fetch looks up a PC and gets a registered taken/target prediction one cycle later.
// Execute-stage resolutions train 2-bit saturating counters and the stored targets.
// A wrong resolution raises a one-cycle mispredict pulse with the correct next PC.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    output logic        p_valid,
    output logic        p_taken,
    output logic [31:0] p_target,
    input  logic        r_valid,
    input  logic [31:0] r_pc,
    input  logic        r_taken,
    input  logic [31:0] r_target,
    input  logic        r_pred_taken,
    input  logic [31:0] r_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // Index and tag together must fit inside the word-aligned part of a 32-bit PC.
    if (IDX_BITS + TAG_BITS > 30) begin : g_param_check
        $error("branch_predictor: IDX_BITS + TAG_BITS must not exceed 30");
    end

    // Two-bit saturating counter step: 11 stays 11 on taken, 00 stays 00 on not-taken.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            if (ctr == 2'b11) nxt = 2'b11;
            else              nxt = ctr + 2'b01;
        end else begin
            if (ctr == 2'b00) nxt = 2'b00;
            else              nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

    // Table storage
    logic                valid_r  [ENTRIES];
    logic [TAG_BITS-1:0] tag_r    [ENTRIES];
    logic [31:0]         target_r [ENTRIES];
    logic [1:0]          ctr_r    [ENTRIES];

    // Registered outputs
    logic        p_valid_r;
    logic        p_taken_r;
    logic [31:0] p_target_r;
    logic        mispredict_r;
    logic [31:0] redirect_pc_r;
    logic [31:0] br_count_r;
    logic [31:0] mp_count_r;

    // Combinational lookup / resolve decode
    logic [IDX_BITS-1:0] f_idx_s;
    logic [TAG_BITS-1:0] f_tag_s;
    logic                f_hit_s;
    logic                f_pred_taken_s;
    logic [31:0]         f_pred_target_s;
    logic [IDX_BITS-1:0] r_idx_s;
    logic [TAG_BITS-1:0] r_tag_s;
    logic                r_hit_s;
    logic                wrong_s;

    // Fetch-side lookup reads the current (pre-update) table contents.
    always_comb begin
        f_idx_s         = f_pc[IDX_BITS+1:2];
        f_tag_s         = f_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
        f_hit_s         = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
        f_pred_taken_s  = f_hit_s && ctr_r[f_idx_s][1];
        if (f_pred_taken_s) begin
            f_pred_target_s = target_r[f_idx_s];
        end else begin
            f_pred_target_s = f_pc + 32'd4;
        end
    end

    // Resolve-side decode: table hit and whether the travelling prediction was wrong.
    always_comb begin
        r_idx_s = r_pc[IDX_BITS+1:2];
        r_tag_s = r_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
        r_hit_s = valid_r[r_idx_s] && (tag_r[r_idx_s] == r_tag_s);
        wrong_s = (r_pred_taken != r_taken) || (r_taken && (r_pred_target != r_target));
    end

    // Table training: bump counter on hit, allocate on taken miss, ignore not-taken miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= 32'd0;
                ctr_r[i]    <= 2'b01;
            end
        end else if (r_valid) begin
            if (r_hit_s) begin
                ctr_r[r_idx_s] <= ctr_next(ctr_r[r_idx_s], r_taken);
                if (r_taken) begin
                    target_r[r_idx_s] <= r_target;
                end
            end else if (r_taken) begin
                valid_r[r_idx_s]  <= 1'b1;
                tag_r[r_idx_s]    <= r_tag_s;
                target_r[r_idx_s] <= r_target;
                ctr_r[r_idx_s]    <= 2'b10;
            end
        end
    end

    // Prediction register: taken/target hold while no lookup is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_r  <= 1'b0;
            p_taken_r  <= 1'b0;
            p_target_r <= 32'd0;
        end else if (f_valid) begin
            p_valid_r  <= 1'b1;
            p_taken_r  <= f_pred_taken_s;
            p_target_r <= f_pred_target_s;
        end else begin
            p_valid_r  <= 1'b0;
        end
    end

    // Redirect register: one-cycle pulse per wrong resolution, PC held between resolutions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_r  <= 1'b0;
            redirect_pc_r <= 32'd0;
        end else begin
            mispredict_r <= r_valid && wrong_s;
            if (r_valid) begin
                redirect_pc_r <= r_taken ? r_target : (r_pc + 32'd4);
            end
        end
    end

    // Statistics counters, free-running modulo 2**32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_r <= 32'd0;
            mp_count_r <= 32'd0;
        end else begin
            if (r_valid) begin
                br_count_r <= br_count_r + 32'd1;
            end
            if (r_valid && wrong_s) begin
                mp_count_r <= mp_count_r + 32'd1;
            end
        end
    end

    assign p_valid     = p_valid_r;
    assign p_taken     = p_taken_r;
    assign p_target    = p_target_r;
    assign mispredict  = mispredict_r;
    assign redirect_pc = redirect_pc_r;
    assign br_count    = br_count_r;
    assign mp_count    = mp_count_r;

endmodule
